acam_fifo_readout: RTL and testbench
====================================

Name: acam_fifo_readout

Overview:
- Readout stage between the ACAM TDC-GPX FIFO1 pins (empty flag EF1, read strobe RD_N, 28-bit data bus) and the downstream timestamp-processing pipeline.
- Watches the asynchronous empty flag and generates correctly timed RD_N pulses.
- Captures each 28-bit FIFO word and presents it, with its fields split out, on a single-entry valid/ready output register.
- One read in flight at a time; downstream back-pressure stalls further reads, so no data is lost.

Parameters:
- g_rd_low_cycles, 2: clk_sys_i cycles RD_N is held low (range 1..15).
- g_rd_high_cycles, 2: minimum clk_sys_i cycles RD_N stays high after a read (range 1..15).
- g_settle_cycles, 3: cycles waited after RD_N rises before synchronized EF1 is trusted again. Must be ≥ synchronizer depth + 1.
- g_fifo_addr, 8: constant ACAM register address driven on acam_adr_o (FIFO1).

Ports:
- clk_sys_i  in  1  system clock, 62.5 MHz
- rst_sys_i  in  1  asynchronous, active-high reset
- enable_i  in  1  1 = readout allowed
- acam_ef_i  in  1  ACAM FIFO1 empty flag, asynchronous, 1 = empty
- acam_d_i  in  28  ACAM data bus
- acam_rd_n_o  out  1  ACAM read strobe, active low
- acam_oe_n_o  out  1  ACAM output enable, active low
- acam_adr_o  out  4  ACAM address
- ts_valid_o  out  1  output word valid
- ts_ready_i  in  1  downstream accepts the word
- ts_raw_o  out  28  captured word
- ts_chan_o  out  2  acam_d_i[27:26]
- ts_start_nb_o  out  8  acam_d_i[25:18]
- ts_fine_o  out  17  acam_d_i[16:0]
- busy_o  out  1  FSM not in IDLE
- rd_count_o  out  32  total words read; wraps at 2^32

Behaviour:
Reset
- Asynchronous, active-high. Every output register takes its reset value immediately, including during a read in progress.
- Reset values: acam_rd_n_o=1, acam_oe_n_o=1, ts_valid_o=0, ts_raw_o=0, busy_o=0, rd_count_o=0, FSM=IDLE.
- acam_adr_o is the constant g_fifo_addr.
- A reset in the middle of a read releases RD_N at once. The word being read is discarded and not counted.

Input handling
- acam_ef_i passes through a 2-FF synchronizer (reset value 1) to give ef_s.
- acam_oe_n_o = ~enable_i, registered.

FSM states: IDLE, RD_LOW, RD_HIGH, SETTLE.
- IDLE → RD_LOW when enable_i=1, ef_s=0 and (ts_valid_o=0 or ts_ready_i=1). In the same edge, acam_rd_n_o←0.
- RD_LOW: counter runs g_rd_low_cycles cycles.
  - On its last cycle, acam_d_i is registered into the capture register; acam_rd_n_o←1; rd_count_o increments; → RD_HIGH.
- RD_HIGH: g_rd_high_cycles cycles → SETTLE.
- SETTLE: g_settle_cycles cycles → IDLE.
- From IDLE, a new read can start on the next edge, so the back-to-back read period is 1 + g_rd_low + g_rd_high + g_settle cycles (8 cycles at defaults).
- enable_i falling during RD_LOW, RD_HIGH or SETTLE does not truncate the sequence. The current read completes and the FSM then stays in IDLE.
- ef_s is ignored outside IDLE.

Output register
- The captured word loads into ts_* with ts_valid_o←1 on the cycle after the RD_N rising edge.
- ts_valid_o clears on a cycle where valid=1 and ready=1, unless a new word loads in that same cycle (then it stays 1).
- ts_* fields are stable while valid=1 and ready=0.
- Latency: the IDLE start condition seen at edge N gives ts_valid_o=1 after edge N+1+g_rd_low_cycles.
- Simultaneous load and accept: load wins, valid stays 1. This cannot lose data because a read starts only when the register will be free.

Misc
- busy_o = (state != IDLE).

Decomposition:
- Package acam_readout_pkg:
  - field constants: c_chan_msb/lsb=27/26, c_start_nb_msb/lsb=25/18, c_fine_msb/lsb=16/0;
  - c_acam_fifo1_addr=8;
  - state enum t_acam_rd_state.
- Sub-module gc_sync_ffs_2 (reset-value-parameterised 2-FF synchronizer) for acam_ef_i.
- Everything else stays in one module.

Test Plan:
- Single word: EF1 goes 1→0 with acam_d_i=0x6A5_1234 and ts_ready_i=1.
  - Expect: one RD_N low pulse of 2 cycles; ts_raw_o=0x6A51234, ts_chan_o=1, ts_start_nb_o=0xA9, ts_fine_o=0x11234; rd_count_o=1.
- FIFO drains after one read: EF1 returns to 1 within 10 ns of RD_N low.
  - Expect: exactly one read; FSM back in IDLE 8 cycles after start; busy_o=0.
- Burst: EF1 held 0 for 5 words with ready=1.
  - Expect: 5 RD_N pulses exactly 8 cycles apart; rd_count_o=5; words in order.
- Back-pressure: ts_ready_i=0 with 3 words pending.
  - Expect: one read only; ts_valid_o stays 1 with stable data.
  - Raise ready for 1 cycle: the next read starts on that edge.
  - Total 3 words, none dropped.
- enable_i drops in the cycle after RD_N falls.
  - Expect: pulse still lasts 2 cycles; word delivered; no further reads while EF1=0; acam_oe_n_o=1.
- rst_sys_i asserted during RD_LOW.
  - Expect: acam_rd_n_o=1 asynchronously; ts_valid_o=0; rd_count_o=0; after release with EF1=0, a normal read resumes.

Source files
------------

// File: rtl/acam_readout_pkg.sv
// Shared constants and types for the ACAM TDC-GPX FIFO1 readout.
// Field positions follow the FIFO1 word layout.
package acam_readout_pkg;

  localparam int c_chan_msb     = 27;
  localparam int c_chan_lsb     = 26;
  localparam int c_start_nb_msb = 25;
  localparam int c_start_nb_lsb = 18;
  localparam int c_fine_msb     = 16;
  localparam int c_fine_lsb     = 0;

  localparam int c_acam_fifo1_addr = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_LOW,
    ST_RD_HIGH,
    ST_SETTLE
  } t_acam_rd_state;

endpackage

// File: rtl/acam_fifo_readout_if.sv
// Valid/ready timestamp bus between the ACAM readout and the
// timestamp-processing pipeline.
interface acam_fifo_readout_if;

  logic        ts_valid_o;
  logic        ts_ready_i;
  logic [27:0] ts_raw_o;
  logic [1:0]  ts_chan_o;
  logic [7:0]  ts_start_nb_o;
  logic [16:0] ts_fine_o;

  modport master (
    output ts_valid_o,
    output ts_raw_o,
    output ts_chan_o,
    output ts_start_nb_o,
    output ts_fine_o,
    input  ts_ready_i
  );

  modport slave (
    input  ts_valid_o,
    input  ts_raw_o,
    input  ts_chan_o,
    input  ts_start_nb_o,
    input  ts_fine_o,
    output ts_ready_i
  );

endinterface

// File: rtl/gc_sync_ffs_2.sv
// Two-flop synchronizer with a selectable reset value.
// Used to bring the asynchronous ACAM empty flag into clk_sys_i.
module gc_sync_ffs_2 #(
  parameter logic g_rst_val = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= g_rst_val;
      q_o    <= g_rst_val;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/acam_fifo_readout.sv
// ACAM TDC-GPX FIFO1 readout: paces RD_N pulses off the empty
// flag and hands each word to a single-entry valid/ready register.
module acam_fifo_readout
  import acam_readout_pkg::*;
#(
  parameter int g_rd_low_cycles  = 2,
  parameter int g_rd_high_cycles = 2,
  parameter int g_settle_cycles  = 3,
  parameter int g_fifo_addr      = c_acam_fifo1_addr
) (
  input  logic                       clk_sys_i,
  input  logic                       rst_sys_i,
  input  logic                       enable_i,
  input  logic                       acam_ef_i,
  input  logic [27:0]                acam_d_i,
  output logic                       acam_rd_n_o,
  output logic                       acam_oe_n_o,
  output logic [3:0]                 acam_adr_o,
  acam_fifo_readout_if.master        ts,
  output logic                       busy_o,
  output logic [31:0]                rd_count_o
);

  localparam logic [3:0] c_low_last  = 4'(g_rd_low_cycles - 1);
  localparam logic [3:0] c_high_last = 4'(g_rd_high_cycles - 1);
  localparam logic [3:0] c_sett_last = 4'(g_settle_cycles - 1);

  t_acam_rd_state state;
  logic [3:0]     cnt;
  logic           ef_s;
  logic           rd_n_q;
  logic           oe_n_q;
  logic [27:0]    cap_q;
  logic           load_q;
  logic [31:0]    rd_cnt_q;
  logic           start;

  logic           valid_q;
  logic [27:0]    raw_q;
  logic [1:0]     chan_q;
  logic [7:0]     start_nb_q;
  logic [16:0]    fine_q;

  gc_sync_ffs_2 #(
    .g_rst_val (1'b1)
  ) u_ef_sync (
    .clk_i (clk_sys_i),
    .rst_i (rst_sys_i),
    .d_i   (acam_ef_i),
    .q_o   (ef_s)
  );

  // Only start when the output register is guaranteed free at load time.
  assign start = enable_i && !ef_s
              && (!valid_q || ts.ts_ready_i);

  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      rd_n_q   <= 1'b1;
      cap_q    <= '0;
      load_q   <= 1'b0;
      rd_cnt_q <= '0;
    end else begin
      load_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_RD_LOW;
            cnt    <= '0;
            rd_n_q <= 1'b0;
          end
        end
        ST_RD_LOW: begin
          if (cnt == c_low_last) begin
            state    <= ST_RD_HIGH;
            cnt      <= '0;
            cap_q    <= acam_d_i;
            rd_n_q   <= 1'b1;
            load_q   <= 1'b1;
            rd_cnt_q <= rd_cnt_q + 32'd1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_RD_HIGH: begin
          if (cnt == c_high_last) begin
            state <= ST_SETTLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_SETTLE: begin
          if (cnt == c_sett_last) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          cnt    <= '0;
          rd_n_q <= 1'b1;
        end
      endcase
    end
  end

  // A load overrides an accept in the same cycle.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      valid_q    <= 1'b0;
      raw_q      <= '0;
      chan_q     <= '0;
      start_nb_q <= '0;
      fine_q     <= '0;
    end else if (load_q) begin
      valid_q    <= 1'b1;
      raw_q      <= cap_q;
      chan_q     <= cap_q[c_chan_msb:c_chan_lsb];
      start_nb_q <= cap_q[c_start_nb_msb:c_start_nb_lsb];
      fine_q     <= cap_q[c_fine_msb:c_fine_lsb];
    end else if (valid_q && ts.ts_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      oe_n_q <= 1'b1;
    end else begin
      oe_n_q <= ~enable_i;
    end
  end

  assign acam_rd_n_o      = rd_n_q;
  assign acam_oe_n_o      = oe_n_q;
  assign acam_adr_o       = 4'(g_fifo_addr);
  assign busy_o           = (state != ST_IDLE);
  assign rd_count_o       = rd_cnt_q;
  assign ts.ts_valid_o    = valid_q;
  assign ts.ts_raw_o      = raw_q;
  assign ts.ts_chan_o     = chan_q;
  assign ts.ts_start_nb_o = start_nb_q;
  assign ts.ts_fine_o     = fine_q;

endmodule

// File: tb/tb_acam_fifo_readout.sv
// Bench for acam_fifo_readout: a queue-based ACAM FIFO model feeds
// the DUT and a scoreboard checks words, counts and RD_N timing.
module tb_acam_fifo_readout;

  logic        clk_sys_i = 1'b0;
  logic        rst_sys_i = 1'b1;
  logic        enable_i  = 1'b0;
  logic        acam_ef_i = 1'b1;
  logic [27:0] acam_d_i  = '0;
  logic        acam_rd_n_o;
  logic        acam_oe_n_o;
  logic [3:0]  acam_adr_o;
  logic        busy_o;
  logic [31:0] rd_count_o;

  acam_fifo_readout_if ts_if ();

  acam_fifo_readout dut (
    .clk_sys_i   (clk_sys_i),
    .rst_sys_i   (rst_sys_i),
    .enable_i    (enable_i),
    .acam_ef_i   (acam_ef_i),
    .acam_d_i    (acam_d_i),
    .acam_rd_n_o (acam_rd_n_o),
    .acam_oe_n_o (acam_oe_n_o),
    .acam_adr_o  (acam_adr_o),
    .ts          (ts_if.master),
    .busy_o      (busy_o),
    .rd_count_o  (rd_count_o)
  );

  always #8 clk_sys_i = ~clk_sys_i;

  int n_chk = 0;
  int n_err = 0;

  logic [27:0] fifo_q[$];
  logic [27:0] exp_q[$];
  int          falls[$];
  logic [27:0] inflight = '0;
  logic        in_read  = 1'b0;
  int          n_reads  = 0;
  int          pushed   = 0;
  int          accepted = 0;
  int          disc     = 0;
  int          cyc      = 0;
  int          lowcnt   = 0;
  logic        pv       = 1'b0;
  logic        pr       = 1'b0;
  logic [27:0] praw     = '0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(logic [27:0] w);
    fifo_q.push_back(w);
    pushed++;
    acam_ef_i = 1'b0;
  endtask

  // ACAM FIFO model: a word is popped as RD_N falls, flag follows.
  always @(negedge acam_rd_n_o) begin
    #2;
    if (fifo_q.size() != 0) begin
      inflight = fifo_q.pop_front();
      acam_d_i = inflight;
      in_read  = 1'b1;
    end
    acam_ef_i = (fifo_q.size() == 0);
  end

  always @(posedge acam_rd_n_o) begin
    if (in_read) begin
      in_read = 1'b0;
      if (rst_sys_i) begin
        disc++;
      end else begin
        exp_q.push_back(inflight);
        n_reads++;
      end
      #2 acam_d_i = 28'($urandom);
    end
  end

  always @(posedge rst_sys_i) begin
    disc    = disc + exp_q.size();
    exp_q.delete();
    n_reads = 0;
  end

  always @(posedge clk_sys_i) cyc++;

  always @(negedge clk_sys_i) begin
    if (rst_sys_i) begin
      lowcnt = 0;
      pv     = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("stall_valid", 64'(ts_if.ts_valid_o), 64'd1);
        chk("stall_raw", 64'(ts_if.ts_raw_o), 64'(praw));
      end
      if (ts_if.ts_valid_o && ts_if.ts_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 64'd1, 64'd0);
        end else begin
          logic [27:0] w;
          w = exp_q.pop_front();
          chk("word_raw", 64'(ts_if.ts_raw_o), 64'(w));
          chk("word_chan", 64'(ts_if.ts_chan_o), 64'(w >> 26));
          chk("word_start", 64'(ts_if.ts_start_nb_o),
              64'((w >> 18) & 28'hFF));
          chk("word_fine", 64'(ts_if.ts_fine_o),
              64'(w & 28'h1FFFF));
          chk("word_count", 64'(rd_count_o), 64'(n_reads));
          accepted++;
        end
      end
      if (!acam_rd_n_o) begin
        if (lowcnt == 0) falls.push_back(cyc);
        lowcnt++;
      end else if (lowcnt != 0) begin
        chk("rd_low_width", 64'(lowcnt), 64'd2);
        lowcnt = 0;
      end
      pv   = ts_if.ts_valid_o;
      pr   = ts_if.ts_ready_i;
      praw = ts_if.ts_raw_o;
    end
  end

  task automatic wait_rd_low(string tag);
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clk_sys_i);
      if (!acam_rd_n_o) break;
    end
    if (i == 100) chk(tag, 64'd0, 64'd1);
  endtask

  task automatic wait_drain();
    int i;
    @(posedge clk_sys_i);
    #1;
    enable_i         = 1'b1;
    ts_if.ts_ready_i = 1'b1;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk_sys_i);
      if (fifo_q.size() == 0 && exp_q.size() == 0 && !busy_o
          && !ts_if.ts_valid_o) break;
    end
    if (i == 3000) chk("drain_timeout", 64'd0, 64'd1);
    repeat (4) @(negedge clk_sys_i);
  endtask

  initial begin
    int acc0;
    int i;
    ts_if.ts_ready_i = 1'b1;
    #40;
    chk("rst_rd_n", 64'(acam_rd_n_o), 64'd1);
    chk("rst_oe_n", 64'(acam_oe_n_o), 64'd1);
    chk("rst_valid", 64'(ts_if.ts_valid_o), 64'd0);
    chk("rst_raw", 64'(ts_if.ts_raw_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_count", 64'(rd_count_o), 64'd0);
    chk("adr", 64'(acam_adr_o), 64'd8);
    @(posedge clk_sys_i);
    #1;
    rst_sys_i = 1'b0;
    enable_i  = 1'b1;

    // Single word, FIFO drains right after the read.
    repeat (3) @(negedge clk_sys_i);
    chk("oe_on", 64'(acam_oe_n_o), 64'd0);
    falls.delete();
    push(28'h6A51234);
    wait_rd_low("single_start_timeout");
    repeat (2) @(negedge clk_sys_i);
    chk("lat_early", 64'(ts_if.ts_valid_o), 64'd0);
    @(negedge clk_sys_i);
    chk("lat_valid", 64'(ts_if.ts_valid_o), 64'd1);
    chk("single_raw", 64'(ts_if.ts_raw_o), 64'h6A51234);
    chk("single_chan", 64'(ts_if.ts_chan_o), 64'd1);
    chk("single_start", 64'(ts_if.ts_start_nb_o), 64'hA9);
    chk("single_fine", 64'(ts_if.ts_fine_o), 64'h11234);
    chk("single_count", 64'(rd_count_o), 64'd1);
    repeat (3) @(negedge clk_sys_i);
    chk("busy_end", 64'(busy_o), 64'd1);
    @(negedge clk_sys_i);
    chk("idle_after8", 64'(busy_o), 64'd0);
    repeat (20) @(negedge clk_sys_i);
    chk("single_reads", 64'(falls.size()), 64'd1);

    // Burst of five with ready held high.
    falls.delete();
    for (i = 0; i < 5; i++) push(28'($urandom));
    wait_drain();
    chk("burst_reads", 64'(falls.size()), 64'd5);
    for (i = 1; i < falls.size(); i++)
      chk("burst_period", 64'(falls[i] - falls[i-1]), 64'd8);
    chk("burst_count", 64'(rd_count_o), 64'd6);

    // Back-pressure with three words pending.
    @(posedge clk_sys_i);
    #1;
    ts_if.ts_ready_i = 1'b0;
    falls.delete();
    acc0 = accepted;
    for (i = 0; i < 3; i++) push(28'($urandom));
    repeat (40) @(negedge clk_sys_i);
    chk("bp_reads", 64'(falls.size()), 64'd1);
    chk("bp_valid", 64'(ts_if.ts_valid_o), 64'd1);
    @(posedge clk_sys_i);
    #1;
    ts_if.ts_ready_i = 1'b1;
    @(posedge clk_sys_i);
    #1;
    ts_if.ts_ready_i = 1'b0;
    @(negedge clk_sys_i);
    chk("bp_restart", 64'(acam_rd_n_o), 64'd0);
    repeat (40) @(negedge clk_sys_i);
    chk("bp_reads2", 64'(falls.size()), 64'd2);
    wait_drain();
    chk("bp_words", 64'(accepted - acc0), 64'd3);

    // Enable drops one cycle after RD_N falls.
    falls.delete();
    acc0 = accepted;
    for (i = 0; i < 3; i++) push(28'($urandom));
    wait_rd_low("en_start_timeout");
    @(posedge clk_sys_i);
    #1;
    enable_i = 1'b0;
    repeat (40) @(negedge clk_sys_i);
    chk("en_reads", 64'(falls.size()), 64'd1);
    chk("en_words", 64'(accepted - acc0), 64'd1);
    chk("en_oe_n", 64'(acam_oe_n_o), 64'd1);
    chk("en_busy", 64'(busy_o), 64'd0);
    wait_drain();

    // Reset in the middle of RD_LOW.
    push(28'($urandom));
    push(28'($urandom));
    wait_rd_low("rst_start_timeout");
    #2;
    rst_sys_i = 1'b1;
    #1;
    chk("mid_rst_rd_n", 64'(acam_rd_n_o), 64'd1);
    chk("mid_rst_valid", 64'(ts_if.ts_valid_o), 64'd0);
    chk("mid_rst_count", 64'(rd_count_o), 64'd0);
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    repeat (2) @(posedge clk_sys_i);
    #1;
    rst_sys_i = 1'b0;
    for (i = 0; i < 60; i++) begin
      @(negedge clk_sys_i);
      if (ts_if.ts_valid_o) break;
    end
    if (i == 60) chk("post_rst_timeout", 64'd0, 64'd1);
    chk("post_rst_count", 64'(rd_count_o), 64'd1);
    wait_drain();

    // Random traffic, ready and enable.
    for (i = 0; i < 600; i++) begin
      @(posedge clk_sys_i);
      #1;
      if ($urandom_range(0, 3) == 0) push(28'($urandom));
      ts_if.ts_ready_i = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 40) == 0) enable_i = ~enable_i;
    end
    wait_drain();
    chk("total_words", 64'(accepted + disc), 64'(pushed));
    chk("fifo_empty", 64'(fifo_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
